seq_divider: RTL

Sequential restoring divider: the inverse companion of the team's shift-add sequential multiplier. Takes a WIDTH-bit dividend and divisor on a `load` strobe, produces quotient and remainder one bit per clock, and presents the result with a `valid` flag held until the next load. Sits beside the multiplier in the arithmetic datapath; verification checks that divider output multiplied back reproduces the dividend.

---
 rtl/seq_div_pkg.sv | 21 ++
 rtl/seq_div_step.sv | 27 ++
 rtl/seq_divider.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_div_state_t;

  // Widest operand supported; constants below are sized to it and sliced down.
  localparam int unsigned MAX_WIDTH = 32;

  // Quotient reported on divide-by-zero: all ones (-1 in two's complement).
  localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

  // Iteration counter width, enough to hold 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module seq_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             ge;

  // The partial remainder is always below b, so the shifted value stays
  // under 2^(WIDTH+1) and the top bit of trial is a clean sign bit.
  always_comb begin
    shifted = {rem_i[WIDTH-1:0], q_i[WIDTH-1]};
    trial   = {rem_i, q_i[WIDTH-1]} - {2'b00, b_i};
    ge      = ~trial[WIDTH+1];
    rem_o   = ge ? trial[WIDTH:0] : shifted;
    q_o     = {q_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional macro SEQ_DIV_SIGNED_EN: two's-complement operands (sign-magnitude
// around the unsigned core, correction applied on DONE entry).
//
// state | meaning
// IDLE  | after reset, waiting for load
// RUN   | iterating, WIDTH cycles
// DONE  | result valid, waiting for next load
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             dbz_o
);

  localparam int CW = cnt_width(WIDTH);

  seq_div_state_t   state_q;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_op, b_op;
  logic [WIDTH-1:0] q_fix, r_fix;

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .q_i   (q_q),
    .b_i   (b_q),
    .rem_o (rem_d),
    .q_o   (q_d)
  );

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q_q, neg_r_q;

  // Core divides magnitudes; the most-negative value maps onto itself,
  // which as an unsigned magnitude is exactly right.
  always_comb begin
    a_op = a_i[WIDTH-1] ? (-a_i) : a_i;
    b_op = b_i[WIDTH-1] ? (-b_i) : b_i;
  end

  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  always_comb begin
    q_fix = neg_q_q ? (-q_d) : q_d;
    r_fix = neg_r_q ? (-rem_d[WIDTH-1:0]) : rem_d[WIDTH-1:0];
  end

  // Operand signs captured with the magnitudes on an accepted load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (state_q != RUN && load_i && b_i != '0) begin
      neg_q_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
      neg_r_q <= a_i[WIDTH-1];
    end
  end
`else
  // Unsigned: operands and results pass straight through.
  always_comb begin
    a_op  = a_i;
    b_op  = b_i;
    q_fix = q_d;
    r_fix = rem_d[WIDTH-1:0];
  end
`endif

  // Control FSM, iteration registers and registered result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      q_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      quotient_o  <= '0;
      remainder_o <= '0;
      valid_o     <= 1'b0;
      busy_o      <= 1'b0;
      dbz_o       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (load_i) begin
            if (b_i == '0) begin
              state_q     <= DONE;
              quotient_o  <= DBZ_QUOTIENT[WIDTH-1:0];
              remainder_o <= a_i;
              valid_o     <= 1'b1;
              dbz_o       <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_o  <= 1'b1;
              valid_o <= 1'b0;
              dbz_o   <= 1'b0;
              q_q     <= a_op;
              b_q     <= b_op;
              rem_q   <= '0;
              cnt_q   <= '0;
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q     <= DONE;
            busy_o      <= 1'b0;
            valid_o     <= 1'b1;
            quotient_o  <= q_fix;
            remainder_o <= r_fix;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
